// File: rtl/dbbif_ext_burst_writer.sv
// Purpose: turns a linear copy command plus a data stream into INCR write bursts on ext2dbb.
// Latency: AW valid the cycle after command accept; done pulses the cycle after the final B.
// Backpressure: awready/wready stall the FSM; s_ready mirrors wready only while in W.
module dbbif_ext_burst_writer #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 64,
    parameter int         MAX_BURST  = 16,
    parameter logic [7:0] AXI_ID     = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [15:0]             cmd_beats,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    done,
    output logic                    err,
    output logic                    ext2dbb_awvalid,
    input  logic                    ext2dbb_awready,
    output logic [7:0]              ext2dbb_awlen,
    output logic [2:0]              ext2dbb_awsize,
    output logic [1:0]              ext2dbb_awburst,
    output logic [ADDR_WIDTH-1:0]   ext2dbb_awaddr,
    output logic [7:0]              ext2dbb_awid,
    output logic                    ext2dbb_wvalid,
    input  logic                    ext2dbb_wready,
    output logic [DATA_WIDTH-1:0]   ext2dbb_wdata,
    output logic                    ext2dbb_wlast,
    output logic [DATA_WIDTH/8-1:0] ext2dbb_wstrb,
    input  logic                    ext2dbb_bvalid,
    output logic                    ext2dbb_bready,
    input  logic [7:0]              ext2dbb_bid
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [15:0]           r_rem, w_rem_nxt;
    logic [8:0]            r_bcnt, w_bcnt_nxt;
    logic [8:0]            r_len, w_len_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_rst_d;

    logic [12:0]           w_room_bytes;
    logic [12:0]           w_room_beats;
    logic [8:0]            w_cap;
    logic [8:0]            w_len;
    logic                  w_quiet;
    logic                  w_in_idle, w_in_aw, w_in_w, w_in_b;
    logic                  w_aw_fire, w_w_fire, w_b_fire, w_cmd_fire;

    // Outputs are forced quiet during reset and for one cycle after it
    assign w_quiet   = rst | r_rst_d;
    assign w_in_idle = (r_state == S_IDLE) && !w_quiet;
    assign w_in_aw   = (r_state == S_AW)   && !w_quiet;
    assign w_in_w    = (r_state == S_W)    && !w_quiet;
    assign w_in_b    = (r_state == S_B)    && !w_quiet;

    assign w_cmd_fire = cmd_valid && w_in_idle;
    assign w_aw_fire  = w_in_aw && ext2dbb_awready;
    assign w_w_fire   = w_in_w && s_valid && ext2dbb_wready;
    assign w_b_fire   = w_in_b && ext2dbb_bvalid;

    // Beats left before the next 4 KB page; r_addr is always beat aligned so this is >= 1
    assign w_room_bytes = 13'd4096 - {1'b0, r_addr[11:0]};
    assign w_room_beats = w_room_bytes >> LOG2B;

    // Burst length: the smallest of remaining beats, MAX_BURST and room in the page
    always_comb begin
        w_cap = 9'(MAX_BURST);
        if (w_room_beats < 13'(MAX_BURST)) begin
            w_cap = w_room_beats[8:0];
        end
        w_len = w_cap;
        if (r_rem < 16'(w_cap)) begin
            w_len = r_rem[8:0];
        end
    end

    assign cmd_ready       = w_in_idle;
    assign done            = r_done && !w_quiet;
    assign err             = r_err && !w_quiet;

    assign ext2dbb_awvalid = w_in_aw;
    assign ext2dbb_awaddr  = w_in_aw ? r_addr : '0;
    assign ext2dbb_awlen   = w_in_aw ? 8'(w_len - 9'd1) : 8'd0;
    assign ext2dbb_awsize  = w_in_aw ? 3'(LOG2B) : 3'd0;
    assign ext2dbb_awburst = w_in_aw ? 2'b01 : 2'b00;
    assign ext2dbb_awid    = w_in_aw ? AXI_ID : 8'd0;

    assign ext2dbb_wvalid  = w_in_w && s_valid;
    assign s_ready         = w_in_w && ext2dbb_wready;
    assign ext2dbb_wdata   = w_in_w ? s_data : '0;
    assign ext2dbb_wstrb   = w_in_w ? '1 : '0;
    assign ext2dbb_wlast   = w_in_w && (r_bcnt == 9'd1);

    assign ext2dbb_bready  = w_in_b;

    // Next-state logic: one burst in flight, AW then W then B
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_rem_nxt   = r_rem;
        w_bcnt_nxt  = r_bcnt;
        w_len_nxt   = r_len;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    w_addr_nxt = cmd_addr & ALIGN_MASK;
                    w_rem_nxt  = cmd_beats;
                    w_err_nxt  = 1'b0;
                    if (cmd_beats == 16'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_AW;
                    end
                end
            end
            S_AW: begin
                if (w_aw_fire) begin
                    w_bcnt_nxt  = w_len;
                    w_len_nxt   = w_len;
                    w_state_nxt = S_W;
                end
            end
            S_W: begin
                if (w_w_fire) begin
                    w_bcnt_nxt = r_bcnt - 9'd1;
                    w_rem_nxt  = r_rem - 16'd1;
                    if (r_bcnt == 9'd1) begin
                        w_state_nxt = S_B;
                    end
                end
            end
            S_B: begin
                if (w_b_fire) begin
                    if (ext2dbb_bid != AXI_ID) begin
                        w_err_nxt = 1'b1;
                    end
                    w_addr_nxt = r_addr + (ADDR_WIDTH'(r_len) << LOG2B);
                    if (r_rem != 16'd0) begin
                        w_state_nxt = S_AW;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any partial burst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_bcnt  <= '0;
            r_len   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rst_d <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_rem   <= w_rem_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_len   <= w_len_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_rst_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dbbif_ext_burst_writer.sv
// Bench for dbbif_ext_burst_writer: table of directed commands, a mid-burst reset,
// then randomized commands against a burst-splitting reference model.
module tb_dbbif_ext_burst_writer;

    localparam int MB = 16;
    localparam int BY = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic        s_valid, s_ready;
    logic [63:0] s_data;
    logic        done, err;
    logic        awvalid, awready;
    logic [7:0]  awlen, awid;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] awaddr;
    logic        wvalid, wready, wlast;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        bvalid, bready;
    logic [7:0]  bid;

    always #5 clk = ~clk;

    dbbif_ext_burst_writer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_BURST(MB), .AXI_ID(8'h00)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .done(done), .err(err),
        .ext2dbb_awvalid(awvalid), .ext2dbb_awready(awready), .ext2dbb_awlen(awlen),
        .ext2dbb_awsize(awsize), .ext2dbb_awburst(awburst), .ext2dbb_awaddr(awaddr),
        .ext2dbb_awid(awid),
        .ext2dbb_wvalid(wvalid), .ext2dbb_wready(wready), .ext2dbb_wdata(wdata),
        .ext2dbb_wlast(wlast), .ext2dbb_wstrb(wstrb),
        .ext2dbb_bvalid(bvalid), .ext2dbb_bready(bready), .ext2dbb_bid(bid)
    );

    typedef struct {
        logic [31:0] a;
        int          l;
    } burst_t;

    typedef struct {
        logic [31:0] a;
        int          beats;
        int          gap;
        logic [7:0]  bid;
        logic [63:0] d0;
        int          nb;
        logic [31:0] fa;
        int          fl;
    } vec_t;

    int          checks = 0;
    int          errors = 0;

    // Reference state: expected bursts, stream contents, protocol phase
    burst_t      exp_q[$];
    logic [63:0] src[$];
    int          src_idx, wbeat, bib, cur_len, n_aw, first_l, ph, gap_mode, cyc_n;
    logic [31:0] first_a;
    logic        exp_done, err_exp, acc_seen, took, rnd_slave;
    logic [7:0]  bid_val;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Called at the falling edge: compare outputs, then advance the reference for the next edge
    task automatic sample();
        burst_t b;
        chk("cmd_ready", cmd_ready, ph == 0);
        chk("awvalid", awvalid, ph == 1);
        chk("wvalid", wvalid, (ph == 2) && s_valid);
        chk("s_ready", s_ready, (ph == 2) && wready);
        chk("bready", bready, ph == 3);
        chk("done", done, exp_done);
        chk("err", err, err_exp);
        exp_done = 1'b0;
        took = s_valid && s_ready;
        if (ph == 0 && cmd_valid && cmd_ready) begin
            acc_seen = 1'b1;
            err_exp  = 1'b0;
            if (cmd_beats == 16'd0) exp_done = 1'b1;
            else ph = 1;
        end else if (ph == 1 && awvalid && awready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL aw_unexpected actual=%0h required=none", awaddr);
            end else begin
                b = exp_q.pop_front();
                chk("awaddr", awaddr, b.a);
                chk("awlen", awlen, b.l - 1);
                chk("awsize", awsize, 3);
                chk("awburst", awburst, 1);
                chk("awid", awid, 0);
                if (n_aw == 0) begin
                    first_a = awaddr;
                    first_l = int'(awlen);
                end
                n_aw++;
                cur_len = b.l;
                bib = 0;
                ph = 2;
            end
        end else if (ph == 2 && wvalid && wready) begin
            if (wbeat < src.size()) chk("wdata", wdata, src[wbeat]);
            else chk("w_extra", wbeat, src.size() - 1);
            chk("wlast", wlast, bib == cur_len - 1);
            chk("wstrb", wstrb, 8'hFF);
            wbeat++;
            bib++;
            if (bib == cur_len) ph = 3;
        end else if (ph == 3 && bvalid) begin
            if (bid != 8'h00) err_exp = 1'b1;
            if (exp_q.size() == 0) begin
                ph = 0;
                exp_done = 1'b1;
            end else begin
                ph = 1;
            end
        end
    endtask

    // Called just after the rising edge: drive the command, stream and slave responses
    task automatic drive();
        logic sv;
        cmd_valid = cmd_valid && !acc_seen;
        if (took) src_idx++;
        took = 1'b0;
        cyc_n++;
        case (gap_mode)
            0:       sv = 1'b1;
            1:       sv = cyc_n[0];
            default: sv = 1'($urandom_range(0, 1));
        endcase
        s_valid = (src_idx < src.size()) && sv;
        s_data  = (src_idx < src.size()) ? src[src_idx] : {$urandom, $urandom};
        awready = rnd_slave ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = rnd_slave ? ($urandom_range(0, 3) != 0) : 1'b1;
        bvalid  = (ph == 3) && (rnd_slave ? ($urandom_range(0, 1) == 1) : 1'b1);
        bid     = bid_val;
    endtask

    // Expects rst already high; checks quiet outputs during and after reset
    task automatic reset_seq();
        @(negedge clk);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wstrb", wstrb, 0);
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0; s_valid = 1'b0; bvalid = 1'b0;
        ph = 0; exp_done = 1'b0; err_exp = 1'b0; exp_q.delete();
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 0);
        chk("post_rst_awvalid", awvalid, 0);
        chk("post_rst_err", err, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input logic [31:0] a, input int beats, input int gap,
                           input logic [7:0] bidv, input logic [63:0] d0, input int rst_at);
        logic [31:0] ma;
        int          r, l, room;
        logic        fin;
        exp_q.delete();
        src.delete();
        ma = a & ~32'h7;
        r  = beats;
        while (r > 0) begin
            l    = r;
            room = (4096 - int'(ma[11:0])) / BY;
            if (l > MB) l = MB;
            if (l > room) l = room;
            exp_q.push_back('{a: ma, l: l});
            ma = ma + 32'(l * BY);
            r -= l;
        end
        for (int i = 0; i < beats; i++) src.push_back(i == 0 ? d0 : {$urandom, $urandom});
        src_idx = 0; wbeat = 0; n_aw = 0; acc_seen = 1'b0; took = 1'b0;
        bid_val = bidv; gap_mode = gap; fin = 1'b0;
        cmd_addr = a; cmd_beats = 16'(beats); cmd_valid = 1'b1;
        drive();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sample();
            if (acc_seen && ph == 0 && !exp_done) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk); #1;
            drive();
            if (rst_at >= 0 && wbeat == rst_at) begin
                rst = 1'b1;
                reset_seq();
                return;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%0h beats=%0d required=done", a, beats);
        end
        chk("beats_sent", wbeat, beats);
        @(posedge clk); #1;
    endtask

    vec_t tv[9];

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        s_valid = 1'b0; s_data = '0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; bid = '0; rnd_slave = 1'b0; bid_val = '0;
        ph = 0; exp_done = 1'b0; err_exp = 1'b0; cyc_n = 0; gap_mode = 0;

        tv[0] = '{32'h40,       1,  0, 8'h00, 64'h1122334455667788, 1, 32'h40,       0};
        tv[1] = '{32'h100,      40, 0, 8'h00, 64'h0A0B0C0D0E0F1011, 3, 32'h100,      15};
        tv[2] = '{32'hFF0,      4,  0, 8'h00, 64'h5555AAAA5555AAAA, 2, 32'hFF0,      1};
        tv[3] = '{32'h203,      5,  1, 8'h00, 64'hCAFEF00DDEADBEEF, 1, 32'h200,      4};
        tv[4] = '{32'h0,        0,  0, 8'h00, 64'h0,                0, 32'h0,        0};
        tv[5] = '{32'h1000,     2,  0, 8'h5A, 64'h0123456789ABCDEF, 1, 32'h1000,     1};
        tv[6] = '{32'h10,       3,  2, 8'h00, 64'hFEDCBA9876543210, 1, 32'h10,       2};
        tv[7] = '{32'hFFFFFFF8, 3,  0, 8'h00, 64'h1357924680ACEBDF, 2, 32'hFFFFFFF8, 0};
        tv[8] = '{32'h780,      20, 1, 8'h00, 64'h2468ACE013579BDF, 2, 32'h780,      15};

        @(posedge clk); #1;
        reset_seq();

        for (int i = 0; i < 9; i++) begin
            run_cmd(tv[i].a, tv[i].beats, tv[i].gap, tv[i].bid, tv[i].d0, -1);
            chk($sformatf("nbursts_%0d", i), n_aw, tv[i].nb);
            if (tv[i].nb > 0) begin
                chk($sformatf("first_awaddr_%0d", i), first_a, tv[i].fa);
                chk($sformatf("first_awlen_%0d", i), first_l, tv[i].fl);
            end
            if (tv[i].bid != 8'h00) begin
                repeat (3) begin
                    @(negedge clk);
                    chk("err_sticky", err, 1);
                    @(posedge clk); #1;
                end
            end
        end

        // Reset after three of sixteen beats, then a clean single-beat command
        run_cmd(32'h300, 16, 0, 8'h00, 64'h7777666655554444, 3);
        run_cmd(32'h48, 1, 0, 8'h00, 64'h8899AABBCCDDEEFF, -1);
        chk("after_rst_nbursts", n_aw, 1);
        chk("after_rst_awaddr", first_a, 32'h48);

        // Randomized commands with random slave readiness
        rnd_slave = 1'b1;
        for (int k = 0; k < 25; k++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
            run_cmd(ra, $urandom_range(0, 48), $urandom_range(0, 2),
                    ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                    {$urandom, $urandom}, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
